line_engine: RTL

//  Parametrised Bresenham line rasteriser for the vector display path: accepts one

---
 rtl/line_engine_pkg.sv | 22 ++
 rtl/line_engine_step.sv | 43 ++++
 rtl/line_engine.sv | 139 +++++++++++++
 3 files changed

// File: rtl/line_engine_pkg.sv
// Shared types and width helpers for the Bresenham line rasteriser.
package line_engine_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Signed delta, error accumulator and doubled-error widths for a CW-bit coordinate.
   function automatic int dw_f(input int cw);
      return cw + 1;
   endfunction

   function automatic int ew_f(input int cw);
      return cw + 2;
   endfunction

   function automatic int e2w_f(input int cw);
      return cw + 3;
   endfunction

endpackage

// File: rtl/line_engine_step.sv
// One combinational Bresenham step: advances x and/or y and updates the error term.
module line_step
   import line_engine_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic [CW-1:0]        x,
   input  logic [CW-1:0]        y,
   input  logic signed [CW+1:0] err,
   input  logic signed [CW:0]   dx,
   input  logic signed [CW:0]   dy,
   input  logic                 sx_neg,
   input  logic                 sy_neg,
   output logic [CW-1:0]        nx,
   output logic [CW-1:0]        ny,
   output logic signed [CW+1:0] nerr
);

   localparam int EW  = ew_f(CW);
   localparam int E2W = e2w_f(CW);

   logic signed [E2W-1:0] e2, dx_w, dy_w;

   always_comb begin
      e2   = E2W'(err);
      e2   = e2 <<< 1;
      dx_w = E2W'(dx);
      dy_w = E2W'(dy);
      nx   = x;
      ny   = y;
      nerr = err;
      // Both tests use the pre-step error, so a diagonal move applies both updates.
      if (e2 >= dy_w) begin
         nerr = nerr + EW'(dy);
         nx   = sx_neg ? x - CW'(1) : x + CW'(1);
      end
      if (e2 <= dx_w) begin
         nerr = nerr + EW'(dx);
         ny   = sy_neg ? y - CW'(1) : y + CW'(1);
      end
   end

endmodule

// File: rtl/line_engine.sv
// Segment rasteriser: accepts one start/end command, streams every pixel with backpressure.
module line_engine
   import line_engine_pkg::*;
#(
   parameter int CW        = 8,
   parameter bit SKIP_LAST = 1'b0
) (
   input  logic          pclk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [CW-1:0] stax,
   input  logic [CW-1:0] stay,
   input  logic [CW-1:0] endx,
   input  logic [CW-1:0] endy,
   input  logic          abort,
   output logic          pt_valid,
   input  logic          pt_ready,
   output logic [CW-1:0] pt_x,
   output logic [CW-1:0] pt_y,
   output logic          pt_last,
   output logic          busy,
   output logic          done
);

   localparam int DW = dw_f(CW);
   localparam int EW = ew_f(CW);

   state_e                state_q, state_d;
   logic [CW-1:0]         x_q, x_d, y_q, y_d, ex_q, ex_d, ey_q, ey_d;
   logic signed [DW-1:0]  dx_q, dx_d, dy_q, dy_d;
   logic signed [EW-1:0]  err_q, err_d, nerr;
   logic                  sxn_q, sxn_d, syn_q, syn_d, done_q, done_d;
   logic [CW-1:0]         nx, ny, adx, ady;
   logic                  at_end, vld, last;

   line_step #(.CW(CW)) u_step (
      .x      (x_q),
      .y      (y_q),
      .err    (err_q),
      .dx     (dx_q),
      .dy     (dy_q),
      .sx_neg (sxn_q),
      .sy_neg (syn_q),
      .nx     (nx),
      .ny     (ny),
      .nerr   (nerr)
   );

   always_comb begin
      adx    = (endx >= stax) ? endx - stax : stax - endx;
      ady    = (endy >= stay) ? endy - stay : stay - endy;
      at_end = (x_q == ex_q) && (y_q == ey_q);
      // With SKIP_LAST the endpoint itself is never presented, only reached.
      vld    = (state_q == RUN) && !(SKIP_LAST && at_end);
      last   = SKIP_LAST ? ((nx == ex_q) && (ny == ey_q)) : at_end;

      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      ex_d    = ex_q;
      ey_d    = ey_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      sxn_d   = sxn_q;
      syn_d   = syn_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = RUN;
               x_d     = stax;
               y_d     = stay;
               ex_d    = endx;
               ey_d    = endy;
               dx_d    = $signed({1'b0, adx});
               dy_d    = -$signed({1'b0, ady});
               err_d   = $signed({2'b00, adx}) - $signed({2'b00, ady});
               sxn_d   = endx < stax;
               syn_d   = endy < stay;
            end
         end
         default: begin
            if (abort || !vld) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (pt_ready) begin
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  x_d   = nx;
                  y_d   = ny;
                  err_d = nerr;
               end
            end
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         ex_q    <= '0;
         ey_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         sxn_q   <= 1'b0;
         syn_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ex_q    <= ex_d;
         ey_q    <= ey_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         sxn_q   <= sxn_d;
         syn_q   <= syn_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign pt_valid  = vld;
   assign pt_last   = vld && last;
   assign pt_x      = x_q;
   assign pt_y      = y_q;

endmodule
